// File: rtl/hack_cpu_mc.sv
// Multi-cycle Hack CPU with a request/acknowledge data-memory port.
// Define HACK_CPU_HALT_EN to stop the core on a taken jump-to-self.
module hack_cpu_mc #(
   parameter int N      = 16,
   parameter int ADDR_W = 15
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [N-1:0]      inROM,
   output logic [ADDR_W-1:0] PC,
   input  logic [N-1:0]      inRAM,
   output logic [N-1:0]      outRAM,
   output logic [ADDR_W-1:0] addRAM,
   output logic              enM,
   output logic              memReq,
   input  logic              memAck,
   output logic              halted
);

   typedef enum logic [2:0] {
      S_FETCH,
      S_EXEC,
      S_RD_WAIT,
      S_WR_WAIT
`ifdef HACK_CPU_HALT_EN
      , S_HALT
`endif
   } state_t;

   state_t            r_state;
   logic [N-1:0]      r_a;
   logic [N-1:0]      r_d;
   logic [N-1:0]      r_ir;
   logic [ADDR_W-1:0] r_pc;
   logic [ADDR_W-1:0] r_addr;
   logic [N-1:0]      r_out;
   logic              r_en;
   logic              r_req;

   logic              w_isc;
   logic              w_am;
   logic              w_zx, w_nx, w_zy, w_ny, w_f, w_no;
   logic              w_d1, w_d2, w_d3;
   logic              w_j1, w_j2, w_j3;
   logic [N-1:0]      w_x0, w_x1, w_y, w_y0, w_y1;
   logic [N-1:0]      w_pre;
   logic [N-1:0]      w_alu;
   logic              w_zr, w_ng, w_take;
   logic [ADDR_W-1:0] w_tgt;
   logic [ADDR_W-1:0] w_pc_inc;
   logic [ADDR_W-1:0] w_pc_nxt;
   logic [N-1:0]      w_ainst;
   logic              w_unused;

   assign w_isc = r_ir[N-1];
   assign w_am  = r_ir[12];
   assign w_zx  = r_ir[11];
   assign w_nx  = r_ir[10];
   assign w_zy  = r_ir[9];
   assign w_ny  = r_ir[8];
   assign w_f   = r_ir[7];
   assign w_no  = r_ir[6];
   assign w_d1  = r_ir[5];
   assign w_d2  = r_ir[4];
   assign w_d3  = r_ir[3];
   assign w_j1  = r_ir[2];
   assign w_j2  = r_ir[1];
   assign w_j3  = r_ir[0];
   assign w_unused = ^r_ir[N-2:13];

   // M operand is only consumed in RD_WAIT, where inRAM is valid on ack
   assign w_y   = w_am ? inRAM : r_a;
   assign w_x0  = w_zx ? '0 : r_d;
   assign w_x1  = w_nx ? ~w_x0 : w_x0;
   assign w_y0  = w_zy ? '0 : w_y;
   assign w_y1  = w_ny ? ~w_y0 : w_y0;
   assign w_pre = w_f ? (w_x1 + w_y1) : (w_x1 & w_y1);
   assign w_alu = w_no ? ~w_pre : w_pre;
   assign w_zr  = (w_alu == '0);
   assign w_ng  = w_alu[N-1];

   assign w_take   = (w_j1 & w_ng) | (w_j2 & w_zr)
                   | (w_j3 & ~w_ng & ~w_zr);
   assign w_tgt    = r_a[ADDR_W-1:0];
   assign w_pc_inc = r_pc + {{(ADDR_W-1){1'b0}}, 1'b1};
   assign w_pc_nxt = w_take ? w_tgt : w_pc_inc;
   assign w_ainst  = {1'b0, r_ir[N-2:0]};

   assign PC     = r_pc;
   assign addRAM = r_addr;
   assign outRAM = r_out;
   assign enM    = r_en;
   assign memReq = r_req;

`ifdef HACK_CPU_HALT_EN
   logic r_halt;
   assign halted = r_halt;
`else
   assign halted = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= S_FETCH;
         r_a     <= '0;
         r_d     <= '0;
         r_ir    <= '0;
         r_pc    <= '0;
         r_addr  <= '0;
         r_out   <= '0;
         r_en    <= 1'b0;
         r_req   <= 1'b0;
`ifdef HACK_CPU_HALT_EN
         r_halt  <= 1'b0;
`endif
      end else begin
         unique case (r_state)
            S_FETCH: begin
               r_ir    <= inROM;
               r_state <= S_EXEC;
            end
            S_EXEC: begin
               if (!w_isc) begin
                  r_a     <= w_ainst;
                  r_pc    <= w_pc_inc;
                  r_state <= S_FETCH;
               end else if (w_am) begin
                  r_req   <= 1'b1;
                  r_en    <= 1'b0;
                  r_addr  <= w_tgt;
                  r_state <= S_RD_WAIT;
               end else begin
                  if (w_d1) r_a <= w_alu;
                  if (w_d2) r_d <= w_alu;
                  r_pc <= w_pc_nxt;
                  if (w_d3) begin
                     r_addr  <= w_tgt;
                     r_out   <= w_alu;
                     r_req   <= 1'b1;
                     r_en    <= 1'b1;
                     r_state <= S_WR_WAIT;
`ifdef HACK_CPU_HALT_EN
                  end else if (w_take && (w_tgt == r_pc)) begin
                     r_halt  <= 1'b1;
                     r_state <= S_HALT;
`endif
                  end else begin
                     r_state <= S_FETCH;
                  end
               end
            end
            S_RD_WAIT: begin
               if (memAck) begin
                  if (w_d1) r_a <= w_alu;
                  if (w_d2) r_d <= w_alu;
                  r_pc <= w_pc_nxt;
                  // read-modify-write keeps the latched address
                  if (w_d3) begin
                     r_out   <= w_alu;
                     r_en    <= 1'b1;
                     r_state <= S_WR_WAIT;
                  end else begin
                     r_req   <= 1'b0;
                     r_state <= S_FETCH;
                  end
               end
            end
            S_WR_WAIT: begin
               if (memAck) begin
                  r_req   <= 1'b0;
                  r_en    <= 1'b0;
                  r_state <= S_FETCH;
               end
            end
`ifdef HACK_CPU_HALT_EN
            S_HALT: begin
               r_req  <= 1'b0;
               r_halt <= 1'b1;
            end
`endif
            default: r_state <= S_FETCH;
         endcase
      end
   end

endmodule

// File: tb/tb_hack_cpu_mc.sv
// Directed bench for hack_cpu_mc: program table plus reset/handshake sequences.
// Honours HACK_CPU_HALT_EN for the jump-to-self expectation.
module tb_hack_cpu_mc;

   logic        clk;
   logic        rst;
   logic [15:0] inROM;
   logic [14:0] PC;
   logic [15:0] inRAM;
   logic [15:0] outRAM;
   logic [14:0] addRAM;
   logic        enM;
   logic        memReq;
   logic        memAck;
   logic        halted;

   hack_cpu_mc #(.N(16), .ADDR_W(15)) dut (
      .clk    (clk),
      .rst    (rst),
      .inROM  (inROM),
      .PC     (PC),
      .inRAM  (inRAM),
      .outRAM (outRAM),
      .addRAM (addRAM),
      .enM    (enM),
      .memReq (memReq),
      .memAck (memAck),
      .halted (halted)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [15:0] rom [32];
   logic [15:0] ram [128];
   int          ack_lat;
   int          ram_a;
   logic [15:0] ram_d;
   int          cnt;
   int          wr_n, rd_n, req_n;
   logic [15:0] wa, wd;

   assign inROM  = rom[PC[4:0]];
   assign inRAM  = ram[addRAM[6:0]];
   assign memAck = memReq && (ack_lat != 0) && (cnt == ack_lat - 1);

   // memory responder: ack arrives in the ack_lat-th cycle of a request
   always @(posedge clk) begin
      if (!rst) begin
         cnt   <= 0;
         wr_n  <= 0;
         rd_n  <= 0;
         req_n <= 0;
         wa    <= '0;
         wd    <= '0;
         for (int i = 0; i < 128; i++) ram[i] <= '0;
         ram[ram_a[6:0]] <= ram_d;
      end else begin
         cnt <= (!memReq || memAck) ? 0 : cnt + 1;
         if (memReq) req_n <= req_n + 1;
         if (memReq && memAck) begin
            if (enM) begin
               ram[addRAM[6:0]] <= outRAM;
               wr_n <= wr_n + 1;
               wa   <= {1'b0, addRAM};
               wd   <= outRAM;
            end else begin
               rd_n <= rd_n + 1;
            end
         end
      end
   end

   int checks = 0;
   int errors = 0;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   typedef struct {
      string       nm;
      logic [15:0] p [4];
      int          lat;
      int          ra;
      logic [15:0] rd;
      int          cyc;
      int          pc, a, d;
      int          wr, wa, wd, rdn, req, hlt;
   } vec_t;

   vec_t v [10];

   task automatic setv(
      input int i, input string nm,
      input logic [15:0] p0, input logic [15:0] p1,
      input logic [15:0] p2, input logic [15:0] p3,
      input int lat, input int ra, input logic [15:0] rd,
      input int cyc, input int pc, input int a, input int d,
      input int wr, input int wa_e, input int wd_e,
      input int rdn, input int req, input int hlt);
      v[i].nm  = nm;
      v[i].p[0] = p0; v[i].p[1] = p1;
      v[i].p[2] = p2; v[i].p[3] = p3;
      v[i].lat = lat; v[i].ra = ra; v[i].rd = rd;
      v[i].cyc = cyc; v[i].pc = pc; v[i].a = a; v[i].d = d;
      v[i].wr = wr; v[i].wa = wa_e; v[i].wd = wd_e;
      v[i].rdn = rdn; v[i].req = req; v[i].hlt = hlt;
   endtask

   task automatic load(input logic [15:0] p0, input logic [15:0] p1,
                       input logic [15:0] p2, input logic [15:0] p3,
                       input int lat, input int ra,
                       input logic [15:0] rd);
      for (int i = 0; i < 32; i++) rom[i] = 16'h0000;
      rom[0] = p0; rom[1] = p1; rom[2] = p2; rom[3] = p3;
      ack_lat = lat;
      ram_a   = ra;
      ram_d   = rd;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic run(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   localparam logic [15:0] D_A   = 16'hEC10;
   localparam logic [15:0] D_DPA = 16'hE090;
   localparam logic [15:0] M_D   = 16'hE308;
   localparam logic [15:0] M_M1  = 16'hFDC8;
   localparam logic [15:0] AM_M1 = 16'hFDE8;
   localparam logic [15:0] D_M   = 16'hFC10;
   localparam logic [15:0] D_N1  = 16'hEE90;
   localparam logic [15:0] D_1   = 16'hEFD0;
   localparam logic [15:0] D_0   = 16'hEA90;
   localparam logic [15:0] JGT   = 16'hE301;
   localparam logic [15:0] JEQ   = 16'hE302;
   localparam logic [15:0] JMP   = 16'hEA87;

`ifdef HACK_CPU_HALT_EN
   localparam int HLT = 1;
`else
   localparam int HLT = 0;
`endif

   initial begin
      rst = 1'b1;
      ack_lat = 1;
      ram_a = 0;
      ram_d = '0;
      for (int i = 0; i < 32; i++) rom[i] = 16'h0000;

      //   name      p0..p3                           lat ra rd
      //   cyc pc a d wr wa wd rdn req hlt
      setv(0, "ainst", 16'h0005, 0, 0, 0, 1, 0, 0,
           2, 1, 5, 0, 0, 0, 0, 0, 0, 0);
      setv(1, "add", 16'h0007, D_A, 16'h0003, D_DPA, 1, 0, 0,
           8, 4, 3, 10, 0, 0, 0, 0, 0, 0);
      setv(2, "mwrite", 16'h1234, D_A, 16'h0064, M_D, 2, 0, 0,
           10, 4, 100, 16'h1234, 1, 100, 16'h1234, 0, 2, 0);
      setv(3, "rmw", 16'h0014, M_M1, 0, 0, 1, 20, 16'hFFFF,
           6, 2, 20, 0, 1, 20, 0, 1, 2, 0);
      setv(4, "am_rmw", 16'h0014, AM_M1, 0, 0, 1, 20, 16'hFFFF,
           6, 2, 0, 0, 1, 20, 0, 1, 2, 0);
      setv(5, "jgt_neg", D_N1, 16'h0009, JGT, 0, 1, 0, 0,
           6, 3, 9, 16'hFFFF, 0, 0, 0, 0, 0, 0);
      setv(6, "jgt_pos", D_1, 16'h0009, JGT, 0, 1, 0, 0,
           6, 9, 9, 1, 0, 0, 0, 0, 0, 0);
      setv(7, "jeq_zero", D_0, 16'h0009, JEQ, 0, 1, 0, 0,
           6, 9, 9, 0, 0, 0, 0, 0, 0, 0);
      setv(8, "mread", 16'h0014, D_M, 0, 0, 3, 20, 16'hABCD,
           7, 2, 20, 16'hABCD, 0, 0, 0, 1, 3, 0);
      setv(9, "jmp_self", 16'h0002, D_0, JMP, 0, 1, 0, 0,
           10, 2, 2, 0, 0, 0, 0, 0, 0, HLT);

      for (int i = 0; i < 10; i++) begin
         load(v[i].p[0], v[i].p[1], v[i].p[2], v[i].p[3],
              v[i].lat, v[i].ra, v[i].rd);
         do_reset();
         run(v[i].cyc);
         chk({v[i].nm, ".pc"}, {17'd0, PC}, v[i].pc);
         chk({v[i].nm, ".a"}, {16'd0, dut.r_a}, v[i].a);
         chk({v[i].nm, ".d"}, {16'd0, dut.r_d}, v[i].d);
         chk({v[i].nm, ".halted"}, {31'd0, halted}, v[i].hlt);
         chk({v[i].nm, ".writes"}, wr_n, v[i].wr);
         chk({v[i].nm, ".waddr"}, {16'd0, wa}, v[i].wa);
         chk({v[i].nm, ".wdata"}, {16'd0, wd}, v[i].wd);
         chk({v[i].nm, ".reads"}, rd_n, v[i].rdn);
         chk({v[i].nm, ".reqcyc"}, req_n, v[i].req);
         chk({v[i].nm, ".reqidle"}, {31'd0, memReq}, 0);
      end

      // write request held stable until the second-cycle ack
      load(16'h1234, D_A, 16'h0064, M_D, 2, 0, 0);
      do_reset();
      run(8);
      chk("hold0.req", {31'd0, memReq}, 1);
      chk("hold0.en", {31'd0, enM}, 1);
      chk("hold0.addr", {17'd0, addRAM}, 100);
      chk("hold0.out", {16'd0, outRAM}, 16'h1234);
      run(1);
      chk("hold1.req", {31'd0, memReq}, 1);
      chk("hold1.en", {31'd0, enM}, 1);
      chk("hold1.out", {16'd0, outRAM}, 16'h1234);
      run(1);
      chk("hold2.req", {31'd0, memReq}, 0);
      chk("hold2.en", {31'd0, enM}, 0);

      // reset in the middle of a never-acknowledged write
      load(16'h0064, M_D, 0, 0, 0, 0, 0);
      do_reset();
      run(4);
      chk("mid.req", {31'd0, memReq}, 1);
      chk("mid.addr", {17'd0, addRAM}, 100);
      #2;
      rst = 1'b0;
      #1;
      chk("rst.req", {31'd0, memReq}, 0);
      chk("rst.en", {31'd0, enM}, 0);
      chk("rst.addr", {17'd0, addRAM}, 0);
      chk("rst.out", {16'd0, outRAM}, 0);
      chk("rst.pc", {17'd0, PC}, 0);
      chk("rst.halted", {31'd0, halted}, 0);
      rom[0] = 16'h0005;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      run(1);
      chk("rel.pc0", {17'd0, PC}, 0);
      run(1);
      chk("rel.pc1", {17'd0, PC}, 1);
      chk("rel.a", {16'd0, dut.r_a}, 5);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
